// File: rtl/hazard_bypass_unit.sv
// hazard_bypass_unit: tracks in-flight writers after decode, selects bypassed operands and raises load-use stalls
module hazard_bypass_unit #(
  parameter int DATAW      = 32,
  parameter int ADDRW      = 5,
  parameter int NUM_SRC    = 2,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SELW       = $clog2(STAGES + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       issue_valid,
  input  logic [ADDRW-1:0]           issue_rd,
  input  logic                       issue_wen,
  input  logic                       issue_load,
  input  logic                       flush,
  input  logic [NUM_SRC*ADDRW-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]         src_used,
  input  logic [NUM_SRC*DATAW-1:0]   rf_data,
  input  logic [STAGES*DATAW-1:0]    stage_data,
  output logic                       stall,
  output logic [NUM_SRC*SELW-1:0]    fwd_sel,
  output logic [NUM_SRC*DATAW-1:0]   src_data,
  output logic [31:0]                stall_cycles
);
  logic [STAGES:1]   vld, wen, ld;
  logic [ADDRW-1:0]  rd [1:STAGES];
  logic [NUM_SRC-1:0] blk;
  logic [SELW-1:0]   sel [NUM_SRC];
  logic [DATAW-1:0]  fwd [NUM_SRC];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld          <= '0;
      wen          <= '0;
      ld           <= '0;
      stall_cycles <= '0;
      for (int k = 1; k <= STAGES; k++) rd[k] <= '0;
    end else begin
      vld[1] <= issue_valid && !stall && !flush;
      wen[1] <= issue_wen;
      ld[1]  <= issue_load;
      rd[1]  <= issue_rd;
      for (int k = 2; k <= STAGES; k++) begin
        vld[k] <= vld[k-1];
        wen[k] <= wen[k-1];
        ld[k]  <= ld[k-1];
        rd[k]  <= rd[k-1];
      end
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end
  // Scan oldest to youngest so the youngest matching producer is the last to overwrite.
  always_comb begin
    blk      = '0;
    fwd_sel  = '0;
    src_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel[i] = '0;
      fwd[i] = rf_data[i*DATAW +: DATAW];
      for (int k = STAGES; k >= 1; k--) begin
        if (vld[k] && wen[k] && rd[k] != '0 && rd[k] == src_addr[i*ADDRW +: ADDRW] && src_used[i]) begin
          sel[i] = SELW'(k);
          fwd[i] = stage_data[(k-1)*DATAW +: DATAW];
          blk[i] = ld[k] && (k < LOAD_STAGE);
        end
      end
      fwd_sel[i*SELW +: SELW] = sel[i];
      src_data[i*DATAW +: DATAW] = !src_used[i] ? rf_data[i*DATAW +: DATAW] :
                                   src_addr[i*ADDRW +: ADDRW] == '0 ? '0 : fwd[i];
    end
  end
  assign stall = issue_valid && |blk;
endmodule

// File: tb/tb_hazard_bypass_unit.sv
// tb_hazard_bypass_unit: checks two pipeline depths against an in-flight list model plus directed literals
module tb_hazard_bypass_unit;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid, issue_wen, issue_load, flush;
  logic [4:0]  issue_rd;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic [63:0] rf_data;
  logic [31:0] sdv [2][1:4];
  logic [95:0]  sd3;
  logic [127:0] sd4;
  logic         stall3, stall4;
  logic [3:0]   fs3;
  logic [5:0]   fs4;
  logic [63:0]  sdo3, sdo4;
  logic [31:0]  sc3, sc4;
  int n_chk = 0;
  int n_fail = 0;

  assign sd3 = {sdv[0][3], sdv[0][2], sdv[0][1]};
  assign sd4 = {sdv[1][4], sdv[1][3], sdv[1][2], sdv[1][1]};

  always #5 clock = ~clock;

  hazard_bypass_unit #(.STAGES(3), .LOAD_STAGE(2)) dut3 (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_wen(issue_wen), .issue_load(issue_load), .flush(flush), .src_addr(src_addr),
    .src_used(src_used), .rf_data(rf_data), .stage_data(sd3), .stall(stall3),
    .fwd_sel(fs3), .src_data(sdo3), .stall_cycles(sc3));

  hazard_bypass_unit #(.STAGES(4), .LOAD_STAGE(3)) dut4 (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_wen(issue_wen), .issue_load(issue_load), .flush(flush), .src_addr(src_addr),
    .src_used(src_used), .rf_data(rf_data), .stage_data(sd4), .stall(stall4),
    .fwd_sel(fs4), .src_data(sdo4), .stall_cycles(sc4));

  typedef struct packed {bit v; bit wen; bit ld; logic [4:0] rd;} ent_t;
  ent_t        m [2][1:4];
  int          dep [2] = '{3, 4};
  int          lds [2] = '{2, 3};
  int unsigned msc [2];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected operand for source i of instance n: search the in-flight list youngest first.
  function automatic void exp_src(int n, int i, output int sel, output logic [31:0] d, output bit blk);
    logic [4:0] a;
    a = src_addr[i*5 +: 5];
    sel = 0;
    blk = 0;
    d = rf_data[i*32 +: 32];
    if (!src_used[i]) return;
    if (a == 5'd0) begin
      d = '0;
      return;
    end
    for (int k = 1; k <= dep[n]; k++)
      if (m[n][k].v && m[n][k].wen && m[n][k].rd == a) begin
        sel = k;
        d = sdv[n][k];
        blk = m[n][k].ld && k < lds[n];
        return;
      end
  endfunction

  function automatic bit exp_stall(int n);
    int s;
    logic [31:0] d;
    bit b;
    bit any = 0;
    for (int i = 0; i < 2; i++) begin
      exp_src(n, i, s, d, b);
      any |= b;
    end
    return issue_valid && any;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 2; n++) begin
        msc[n] = 0;
        for (int k = 1; k <= 4; k++) m[n][k] = '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        bit st;
        st = exp_stall(n);
        for (int k = dep[n]; k >= 2; k--) m[n][k] = m[n][k-1];
        m[n][1] = '{issue_valid && !st && !flush, issue_wen, issue_load, issue_rd};
        if (st && msc[n] != 32'hFFFF_FFFF) msc[n]++;
      end
    end
  end

  always @(negedge clock) begin
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 2; i++) begin
        int s;
        logic [31:0] d;
        bit b;
        exp_src(n, i, s, d, b);
        chk($sformatf("model_sel%0d_%0d", n, i), n == 0 ? 64'(fs3[i*2 +: 2]) : 64'(fs4[i*3 +: 3]), 64'(s));
        chk($sformatf("model_data%0d_%0d", n, i), n == 0 ? 64'(sdo3[i*32 +: 32]) : 64'(sdo4[i*32 +: 32]), 64'(d));
      end
      chk($sformatf("model_stall%0d", n), n == 0 ? 64'(stall3) : 64'(stall4), 64'(exp_stall(n)));
      chk($sformatf("model_cnt%0d", n), n == 0 ? 64'(sc3) : 64'(sc4), 64'(msc[n]));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic hnd();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    issue_valid = 0; issue_wen = 0; issue_load = 0; flush = 0; issue_rd = '0;
    src_addr = {5'd2, 5'd1};
    src_used = 2'b11;
    rf_data = {32'hBBBB_0002, 32'hAAAA_0001};
    for (int n = 0; n < 2; n++) for (int k = 1; k <= 4; k++) sdv[n][k] = '1;
    repeat (2) hnd();
    chk("rst_stall", 64'(stall3), 64'd0);
    chk("rst_sel", 64'(fs3), 64'd0);
    chk("rst_data", sdo3, 64'hBBBB_0002_AAAA_0001);
    for (int n = 0; n < 2; n++) for (int k = 1; k <= 4; k++) sdv[n][k] = 32'h1000_0000 + n * 32'h100 + k * 32'h11;
    step();
    reset_n = 1'b1;
    hnd();
    chk("post_rst_sel", 64'(fs3), 64'd0);
    chk("post_rst_data", sdo3, 64'hBBBB_0002_AAAA_0001);
    issue_valid = 1; issue_wen = 1; issue_rd = 5'd5;
    step();
    issue_valid = 0; issue_wen = 0; src_addr[4:0] = 5'd5;
    hnd();
    chk("alu_sel1", 64'(fs3[1:0]), 64'd1);
    chk("alu_data1", 64'(sdo3[31:0]), 64'h1000_0011);
    chk("alu_stall", 64'(stall3), 64'd0);
    step();
    hnd();
    chk("alu_sel2", 64'(fs3[1:0]), 64'd2);
    chk("alu_data2", 64'(sdo3[31:0]), 64'h1000_0022);
    src_addr[4:0] = 5'd1;
    issue_valid = 1; issue_wen = 1; issue_load = 1; issue_rd = 5'd7;
    step();
    issue_wen = 0; issue_load = 0; issue_rd = 5'd0; src_addr[9:5] = 5'd7;
    hnd();
    chk("lu_stall3", 64'(stall3), 64'd1);
    chk("lu_stall4", 64'(stall4), 64'd1);
    step();
    hnd();
    chk("lu_release3", 64'(stall3), 64'd0);
    chk("lu_sel3", 64'(fs3[3:2]), 64'd2);
    chk("lu_cnt3", 64'(sc3), 64'd1);
    chk("lu_stall4b", 64'(stall4), 64'd1);
    step();
    hnd();
    chk("lu_release4", 64'(stall4), 64'd0);
    chk("lu_cnt4", 64'(sc4), 64'd2);
    chk("lu_cnt3b", 64'(sc3), 64'd1);
    src_addr[9:5] = 5'd2;
    issue_wen = 1; issue_rd = 5'd3;
    step();
    step();
    issue_valid = 0; issue_wen = 0; src_addr[4:0] = 5'd3;
    hnd();
    chk("young_sel", 64'(fs3[1:0]), 64'd1);
    chk("young_data", 64'(sdo3[31:0]), 64'h1000_0011);
    issue_valid = 1; issue_wen = 1; issue_rd = 5'd0;
    step();
    issue_valid = 0; src_addr[4:0] = 5'd0;
    hnd();
    chk("x0_sel", 64'(fs3[1:0]), 64'd0);
    chk("x0_data", 64'(sdo3[31:0]), 64'd0);
    issue_valid = 1; issue_rd = 5'd4;
    step();
    issue_valid = 0; src_addr[9:5] = 5'd4; src_used = 2'b01;
    hnd();
    chk("unused_sel", 64'(fs3[3:2]), 64'd0);
    chk("unused_stall", 64'(stall3), 64'd0);
    chk("unused_data", 64'(sdo3[63:32]), 64'hBBBB_0002);
    src_used = 2'b11; src_addr[9:5] = 5'd2;
    issue_valid = 1; flush = 1; issue_rd = 5'd9;
    step();
    issue_valid = 0; flush = 0; src_addr[4:0] = 5'd9;
    hnd();
    chk("flush_sel", 64'(fs3[1:0]), 64'd0);
    issue_valid = 1; issue_rd = 5'd6;
    step();
    issue_valid = 0; issue_wen = 0; src_addr[4:0] = 5'd6;
    hnd();
    chk("pre_arst_sel", 64'(fs3[1:0]), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_sel", 64'(fs3[1:0]), 64'd0);
    chk("arst_data", 64'(sdo3[31:0]), 64'hAAAA_0001);
    step();
    reset_n = 1'b1;
    for (int t = 0; t < 40; t++) begin
      issue_valid = (t % 4) != 3;
      issue_rd = 5'(t % 5);
      issue_wen = (t % 6) != 5;
      issue_load = (t % 3) == 0;
      flush = (t % 7) == 6;
      src_addr = {5'((t + 2) % 5), 5'(t % 4 + 1)};
      src_used = (t % 5) == 4 ? 2'b10 : 2'b11;
      step();
    end
    issue_valid = 0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
